// File: rtl/prv664_wb_pkg.sv
// Shared writeback-path types: the FU result entry carried from each FU to
// writeback select, and its reset value.
package prv664_wb_pkg;

    localparam int XLEN         = 64;
    localparam int ITAG_W       = 8;
    localparam int ROB_BANK_BIT = ITAG_W - 1;

    typedef struct packed {
        logic [ITAG_W-1:0] itag;
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   csrdata;
        logic [XLEN-1:0]   branchaddr;
        logic              jump;
        logic [4:0]        fflag;
        logic              mmio;
        logic              load_acc_flt;
        logic              load_addr_mis;
        logic              load_page_flt;
        logic              store_acc_flt;
        logic              store_addr_mis;
        logic              store_page_flt;
    } wb_entry_t;

    localparam wb_entry_t WB_ENTRY_ZERO = '0;

endpackage

// File: rtl/prv664_wb_queue.sv
// Per-FU writeback holding FIFO. Fully registered, so there is no input-to-output
// combinational path; a flush empties the queue in a single cycle.
module prv664_wb_queue
    import prv664_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic                     flush_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  wb_entry_t                s_entry_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output wb_entry_t                m_entry_o,
    output logic                     m_bank_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic              enq, deq;

    // Ready and valid come only from the registered count; when the queue is
    // full, a same-cycle dequeue does not open a slot for the incoming entry.
    assign s_ready_o = (count != CW'(DEPTH));
    assign m_valid_o = (count != '0);
    assign enq       = s_valid_i & s_ready_o;
    assign deq       = m_valid_o & m_ready_i;

    assign m_entry_o = mem[rptr];
    assign m_bank_o  = m_entry_o.itag[ROB_BANK_BIT];
    assign count_o   = count;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + PW'(1);
            if (deq) rptr <= rptr + PW'(1);
            if (enq && !deq)      count <= count + CW'(1);
            else if (deq && !enq) count <= count - CW'(1);
        end
    end

    // Storage is cleared on reset so the head data is never X after reset.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= WB_ENTRY_ZERO;
        end else if (enq && !flush_i) begin
            mem[wptr] <= s_entry_i;
        end
    end

endmodule

// File: tb/tb_prv664_wb_queue.sv
// Checks prv664_wb_queue against a queue-based FIFO reference model, using
// directed scenarios followed by randomized traffic.
module tb_prv664_wb_queue;
    import prv664_wb_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       arst_ni = 1'b0;
    logic       flush = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    wb_entry_t  s_entry = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    wb_entry_t  m_entry;
    logic       m_bank;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_err = 0;
    wb_entry_t q[$];

    prv664_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_entry_i(s_entry),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_entry_o(m_entry),
        .m_bank_o(m_bank), .count_o(count)
    );

    always #5 clk = ~clk;

    // Upstream must hold its entry while stalled.
    logic      prev_stall = 1'b0;
    wb_entry_t prev_ent = '0;
    always @(posedge clk) begin
        if (prev_stall && s_valid)
            assert (s_entry == prev_ent) else $error("stalled entry changed");
        prev_stall <= s_valid && !s_ready;
        prev_ent   <= s_entry;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        chk("count", 256'(count), 256'(q.size()));
        chk("m_valid", 256'(m_valid), 256'(q.size() != 0));
        chk("s_ready", 256'(s_ready), 256'(q.size() != DEPTH));
        if (q.size() != 0) begin
            chk("m_entry", 256'(m_entry), 256'(q[0]));
            chk("m_bank", 256'(m_bank), 256'(q[0].itag >= 8'h80));
        end
    endtask

    // One clock: decide handshakes from the model's occupancy, advance, compare.
    task automatic step();
        bit enq, deq;
        enq = s_valid && (q.size() != DEPTH);
        deq = m_ready && (q.size() != 0);
        @(posedge clk); #1;
        if (flush) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(s_entry);
        end
        compare();
    endtask

    function automatic wb_entry_t mk(input logic [7:0] itag, input logic [63:0] data);
        wb_entry_t e;
        e = '0;
        e.itag = itag;
        e.data = data;
        return e;
    endfunction

    function automatic wb_entry_t rnd_entry();
        wb_entry_t e;
        e.itag           = 8'($urandom);
        e.data           = {$urandom, $urandom};
        e.csrdata        = {$urandom, $urandom};
        e.branchaddr     = {$urandom, $urandom};
        e.jump           = 1'($urandom);
        e.fflag          = 5'($urandom);
        e.mmio           = 1'($urandom);
        e.load_acc_flt   = 1'($urandom);
        e.load_addr_mis  = 1'($urandom);
        e.load_page_flt  = 1'($urandom);
        e.store_acc_flt  = 1'($urandom);
        e.store_addr_mis = 1'($urandom);
        e.store_page_flt = 1'($urandom);
        return e;
    endfunction

    initial begin
        bit stalled;
        repeat (3) @(posedge clk);
        #1 arst_ni = 1'b1;
        compare();
        step();

        // Single enqueue, visible next cycle.
        s_valid = 1'b1; s_entry = mk(8'h05, 64'h1234);
        step();
        s_valid = 1'b0;
        chk("first_itag", 256'(m_entry.itag), 256'(8'h05));
        chk("first_bank", 256'(m_bank), 256'(1'b0));
        step();

        // Fill, stall a third entry, then drain in order.
        flush = 1'b1; step(); flush = 1'b0;
        s_valid = 1'b1; s_entry = mk(8'h85, 64'h1); step();
        s_entry = mk(8'h06, 64'h2); step();
        chk("full_ready", 256'(s_ready), 256'(1'b0));
        s_entry = mk(8'h07, 64'h3); step();
        chk("full_head", 256'(m_entry.itag), 256'(8'h85));
        chk("full_bank", 256'(m_bank), 256'(1'b1));
        m_ready = 1'b1; step();
        chk("drain1", 256'(m_entry.itag), 256'(8'h06));
        step();
        s_valid = 1'b0;
        repeat (2) step();
        m_ready = 1'b0;

        // Streaming at occupancy 1 with pointer wrap.
        s_valid = 1'b1; s_entry = mk(8'h0f, 64'h0); step();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_entry = mk(8'h10 + 8'(i), 64'(i));
            step();
            chk("stream_cnt", 256'(count), 256'(1));
        end
        s_valid = 1'b0; step(); m_ready = 1'b0;

        // Flush at full with a simultaneous enqueue.
        s_valid = 1'b1; s_entry = mk(8'h30, 64'h0); step();
        s_entry = mk(8'h31, 64'h0); step();
        flush = 1'b1; s_entry = mk(8'h20, 64'h0); step();
        flush = 1'b0; s_valid = 1'b0;
        chk("flush_cnt", 256'(count), 256'(0));
        step();

        // Async reset mid-operation.
        s_valid = 1'b1; s_entry = mk(8'h40, 64'h0); step();
        s_entry = mk(8'h41, 64'h0); step();
        s_valid = 1'b0;
        arst_ni = 1'b0;
        #1;
        q.delete();
        chk("arst_valid", 256'(m_valid), 256'(1'b0));
        chk("arst_cnt", 256'(count), 256'(0));
        chk("arst_ready", 256'(s_ready), 256'(1'b1));
        @(posedge clk); #1 arst_ni = 1'b1;
        step();

        // Randomized traffic.
        stalled = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!stalled) begin
                s_valid = ($urandom_range(0, 9) < 7);
                s_entry = rnd_entry();
            end
            m_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 31) == 0);
            stalled = s_valid && (q.size() == DEPTH);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
